branch_target_pipe: RTL and testbench

Registered, multi-lane successor to the ID-stage branch target precompute. Each lane computes PC-relative branch/JAL targets, the link address, and RAS/BTB expected-rs1 values. It also produces BTB correctness and false-hit flags. Results are registered into the ID/EX boundary with stall/flush control. An optional second stage moves the BTB equality compare off the adder path.

---
 rtl/branch_target_pipe_pkg.sv | 69 ++++++
 rtl/branch_target_pipe_lane.sv | 69 ++++++
 rtl/branch_target_pipe.sv | 175 +++++++++++++++++
 tb/tb_branch_target_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_pipe_pkg.sv
// Shared types and helpers for the branch target precompute pipeline.
// Contents:
//   XLEN_MAX       widest datapath the record types can carry
//   LINK_OFS_C/W   link offsets for compressed / full-width instructions
//   lane_result_t  per-lane result record (targets, link, expected rs1s, flags)
//   stage1_t       per-lane record held between adder stage and compare stage
//   btb_correct_f / btb_false_hit_f  BTB flag equations shared by both stages
package branch_target_pipe_pkg;

  localparam int unsigned XLEN_MAX   = 64;
  localparam int unsigned LINK_OFS_C = 2;
  localparam int unsigned LINK_OFS_W = 4;

  // Data fields are carried at XLEN_MAX width and zero-extended from XLEN,
  // so one record type serves every XLEN configuration.
  typedef logic [XLEN_MAX-1:0] word_t;

  typedef struct packed {
    word_t branch_target;
    word_t jal_target;
    word_t link_addr;
    word_t ras_expected_rs1;
    word_t btb_expected_rs1;
    logic  btb_correct_non_jalr;
    logic  btb_false_hit;
  } lane_result_t;

  typedef struct packed {
    word_t branch_target;
    word_t jal_target;
    word_t link_addr;
    word_t ras_expected_rs1;
    word_t btb_expected_rs1;
    word_t btb_target;
    logic  btb_hit;
    logic  is_jal;
    logic  is_jalr;
    logic  is_branch;
  } stage1_t;

  // BTB predicted a direct jump/branch and its target matches the one we computed.
  function automatic logic btb_correct_f(
    input logic  hit,
    input logic  is_jal,
    input logic  is_branch,
    input word_t jal_target,
    input word_t branch_target,
    input word_t btb_target
  );
    word_t sel;
    if (is_jal) begin
      sel = jal_target;
    end else begin
      sel = branch_target;
    end
    return hit & (is_jal | is_branch) & (sel == btb_target);
  endfunction

  // BTB hit on an instruction that is not control flow at all.
  function automatic logic btb_false_hit_f(
    input logic hit,
    input logic is_jal,
    input logic is_jalr,
    input logic is_branch
  );
    return hit & ~(is_jal | is_jalr | is_branch);
  endfunction

endpackage

// File: rtl/branch_target_pipe_lane.sv
// bt_lane_compute: purely combinational target precompute for one lane.
// Ports:
//   valid                      lane carries an instruction (gates the flags)
//   pc, imm_i/b/j              PC and sign-extended immediates
//   ras_target, btb_target     predicted targets
//   btb_hit, is_*              BTB hit and decode flags
//   result                     targets, link, expected rs1 values, BTB flags
// All arithmetic wraps modulo 2^XLEN.
module bt_lane_compute
  import branch_target_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] imm_b,
  input  logic [XLEN-1:0] imm_j,
  input  logic [XLEN-1:0] ras_target,
  input  logic [XLEN-1:0] btb_target,
  input  logic            btb_hit,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_branch,
  input  logic            is_compressed,
  output lane_result_t    result
);

  logic [XLEN-1:0] link_ofs_s;
  logic [XLEN-1:0] branch_target_s;
  logic [XLEN-1:0] jal_target_s;
  logic [XLEN-1:0] link_addr_s;
  logic [XLEN-1:0] ras_rs1_s;
  logic [XLEN-1:0] btb_rs1_s;

  // Link offset: 2-byte step for compressed instructions, 4-byte otherwise.
  always_comb begin
    if (is_compressed) begin
      link_ofs_s = XLEN'(LINK_OFS_C);
    end else begin
      link_ofs_s = XLEN'(LINK_OFS_W);
    end
  end

  // XLEN-wide adders and subtractors; carries out of the top bit are dropped.
  always_comb begin
    branch_target_s = pc + imm_b;
    jal_target_s    = pc + imm_j;
    link_addr_s     = pc + link_ofs_s;
    ras_rs1_s       = ras_target - imm_i;
    btb_rs1_s       = btb_target - imm_i;
  end

  // Pack into the shared record; flags are forced low for an empty lane.
  always_comb begin
    result                      = '0;
    result.branch_target        = word_t'(branch_target_s);
    result.jal_target           = word_t'(jal_target_s);
    result.link_addr            = word_t'(link_addr_s);
    result.ras_expected_rs1     = word_t'(ras_rs1_s);
    result.btb_expected_rs1     = word_t'(btb_rs1_s);
    result.btb_correct_non_jalr = valid & btb_correct_f(btb_hit, is_jal, is_branch,
                                                        word_t'(jal_target_s),
                                                        word_t'(branch_target_s),
                                                        word_t'(btb_target));
    result.btb_false_hit        = valid & btb_false_hit_f(btb_hit, is_jal, is_jalr, is_branch);
  end

endmodule

// File: rtl/branch_target_pipe.sv
// branch_target_pipe: registered multi-lane branch target precompute feeding ID/EX.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_stall, i_flush         hold all stages / invalidate all in-flight lanes
//   i_valid, i_pc, i_imm_*   per-lane instruction inputs
//   i_ras_target, i_btb_*    per-lane predictions
//   i_is_*                   per-lane decode flags
//   o_valid, o_*             per-lane registered results
// Priority per edge: reset > flush > stall > load. SPLIT_COMPARE=1 adds a
// second stage so the BTB equality compare sits after the adder flops.
module branch_target_pipe
  import branch_target_pipe_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_LANES     = 1,
  parameter int unsigned SPLIT_COMPARE = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stall,
  input  logic                           i_flush,
  input  logic [NUM_LANES-1:0]           i_valid,
  input  logic [NUM_LANES-1:0][XLEN-1:0] i_pc,
  input  logic [NUM_LANES-1:0][XLEN-1:0] i_imm_i,
  input  logic [NUM_LANES-1:0][XLEN-1:0] i_imm_b,
  input  logic [NUM_LANES-1:0][XLEN-1:0] i_imm_j,
  input  logic [NUM_LANES-1:0][XLEN-1:0] i_ras_target,
  input  logic [NUM_LANES-1:0][XLEN-1:0] i_btb_target,
  input  logic [NUM_LANES-1:0]           i_btb_hit,
  input  logic [NUM_LANES-1:0]           i_is_jal,
  input  logic [NUM_LANES-1:0]           i_is_jalr,
  input  logic [NUM_LANES-1:0]           i_is_branch,
  input  logic [NUM_LANES-1:0]           i_is_compressed,
  output logic [NUM_LANES-1:0]           o_valid,
  output logic [NUM_LANES-1:0][XLEN-1:0] o_branch_target,
  output logic [NUM_LANES-1:0][XLEN-1:0] o_jal_target,
  output logic [NUM_LANES-1:0][XLEN-1:0] o_link_addr,
  output logic [NUM_LANES-1:0][XLEN-1:0] o_ras_expected_rs1,
  output logic [NUM_LANES-1:0][XLEN-1:0] o_btb_expected_rs1,
  output logic [NUM_LANES-1:0]           o_btb_correct_non_jalr,
  output logic [NUM_LANES-1:0]           o_btb_false_hit
);

  lane_result_t [NUM_LANES-1:0] comb_s;
  lane_result_t [NUM_LANES-1:0] out_r;
  logic         [NUM_LANES-1:0] out_valid_r;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bt_lane_compute #(.XLEN(XLEN)) u_compute (
      .valid         (i_valid[l]),
      .pc            (i_pc[l]),
      .imm_i         (i_imm_i[l]),
      .imm_b         (i_imm_b[l]),
      .imm_j         (i_imm_j[l]),
      .ras_target    (i_ras_target[l]),
      .btb_target    (i_btb_target[l]),
      .btb_hit       (i_btb_hit[l]),
      .is_jal        (i_is_jal[l]),
      .is_jalr       (i_is_jalr[l]),
      .is_branch     (i_is_branch[l]),
      .is_compressed (i_is_compressed[l]),
      .result        (comb_s[l])
    );

    assign o_branch_target[l]        = out_r[l].branch_target[XLEN-1:0];
    assign o_jal_target[l]           = out_r[l].jal_target[XLEN-1:0];
    assign o_link_addr[l]            = out_r[l].link_addr[XLEN-1:0];
    assign o_ras_expected_rs1[l]     = out_r[l].ras_expected_rs1[XLEN-1:0];
    assign o_btb_expected_rs1[l]     = out_r[l].btb_expected_rs1[XLEN-1:0];
    assign o_btb_correct_non_jalr[l] = out_r[l].btb_correct_non_jalr;
    assign o_btb_false_hit[l]        = out_r[l].btb_false_hit;
  end

  assign o_valid = out_valid_r;

  if (SPLIT_COMPARE == 0) begin : g_single

    // Single ID/EX stage: flush drops valid and flags, data may hold.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        out_valid_r <= '0;
        out_r       <= '0;
      end else if (i_flush) begin
        out_valid_r <= '0;
        for (int l = 0; l < NUM_LANES; l++) begin
          out_r[l].btb_correct_non_jalr <= 1'b0;
          out_r[l].btb_false_hit        <= 1'b0;
        end
      end else if (!i_stall) begin
        out_valid_r <= i_valid;
        out_r       <= comb_s;
      end else begin
        out_valid_r <= out_valid_r;
        out_r       <= out_r;
      end
    end

  end else begin : g_split

    stage1_t      [NUM_LANES-1:0] s1_next_s;
    stage1_t      [NUM_LANES-1:0] s1_r;
    logic         [NUM_LANES-1:0] s1_valid_r;
    lane_result_t [NUM_LANES-1:0] s2_s;

    // Stage-1 capture: adder results plus what the deferred compare needs.
    always_comb begin
      s1_next_s = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        s1_next_s[l].branch_target    = comb_s[l].branch_target;
        s1_next_s[l].jal_target       = comb_s[l].jal_target;
        s1_next_s[l].link_addr        = comb_s[l].link_addr;
        s1_next_s[l].ras_expected_rs1 = comb_s[l].ras_expected_rs1;
        s1_next_s[l].btb_expected_rs1 = comb_s[l].btb_expected_rs1;
        s1_next_s[l].btb_target       = word_t'(i_btb_target[l]);
        s1_next_s[l].btb_hit          = i_btb_hit[l];
        s1_next_s[l].is_jal           = i_is_jal[l];
        s1_next_s[l].is_jalr          = i_is_jalr[l];
        s1_next_s[l].is_branch        = i_is_branch[l];
      end
    end

    // Stage-2 compare on registered operands; flags gated by stage-1 valid.
    always_comb begin
      s2_s = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        s2_s[l].branch_target        = s1_r[l].branch_target;
        s2_s[l].jal_target           = s1_r[l].jal_target;
        s2_s[l].link_addr            = s1_r[l].link_addr;
        s2_s[l].ras_expected_rs1     = s1_r[l].ras_expected_rs1;
        s2_s[l].btb_expected_rs1     = s1_r[l].btb_expected_rs1;
        s2_s[l].btb_correct_non_jalr = s1_valid_r[l] &
                                       btb_correct_f(s1_r[l].btb_hit, s1_r[l].is_jal,
                                                     s1_r[l].is_branch, s1_r[l].jal_target,
                                                     s1_r[l].branch_target, s1_r[l].btb_target);
        s2_s[l].btb_false_hit        = s1_valid_r[l] &
                                       btb_false_hit_f(s1_r[l].btb_hit, s1_r[l].is_jal,
                                                       s1_r[l].is_jalr, s1_r[l].is_branch);
      end
    end

    // Both stages advance together; flush clears valid in both at once.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s1_valid_r  <= '0;
        s1_r        <= '0;
        out_valid_r <= '0;
        out_r       <= '0;
      end else if (i_flush) begin
        s1_valid_r  <= '0;
        out_valid_r <= '0;
        for (int l = 0; l < NUM_LANES; l++) begin
          out_r[l].btb_correct_non_jalr <= 1'b0;
          out_r[l].btb_false_hit        <= 1'b0;
        end
      end else if (!i_stall) begin
        s1_valid_r  <= i_valid;
        s1_r        <= s1_next_s;
        out_valid_r <= s1_valid_r;
        out_r       <= s2_s;
      end else begin
        s1_valid_r  <= s1_valid_r;
        s1_r        <= s1_r;
        out_valid_r <= out_valid_r;
        out_r       <= out_r;
      end
    end

  end

  // Upper record bits above XLEN are always zero and the stage-0 flags are
  // unused in the split configuration.
  logic unused_s;
  assign unused_s = ^{out_r, comb_s};

endmodule

// File: tb/tb_branch_target_pipe.sv
module tb_branch_target_pipe;

  typedef struct {
    logic [31:0] pc, imm_i, imm_b, imm_j, ras, btb;
    logic        hit, jal, jalr, br, comp;
    logic [31:0] e_bt, e_jt, e_link, e_ras, e_btb;
    logic        e_cor, e_fh;
  } vec_t;

  typedef struct {
    logic [1:0] mask;
    int         a;
    int         b;
    int         due;
  } exp_t;

  localparam int K_NONE = 0, K_RESET = 1, K_FLUSH = 2, K_STALL = 3, K_LOAD = 4;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [1:0] valid, hit, jal, jalr, br, comp;
  logic [1:0][31:0] pc, imm_i, imm_b, imm_j, ras, btb;

  logic [1:0] ov0, cor0, fh0, ov1, cor1, fh1;
  logic [1:0][31:0] bt0, jt0, lk0, ra0, bb0, bt1, jt1, lk1, ra1, bb1;

  int n_cmp = 0;
  int n_err = 0;
  int adv_cnt = 0;
  int kind = K_NONE;
  exp_t q0[$];
  exp_t q1[$];
  exp_t last_exp [2];

  always #5 clk = ~clk;

  branch_target_pipe #(.XLEN(32), .NUM_LANES(2), .SPLIT_COMPARE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_pc(pc), .i_imm_i(imm_i), .i_imm_b(imm_b), .i_imm_j(imm_j),
    .i_ras_target(ras), .i_btb_target(btb), .i_btb_hit(hit),
    .i_is_jal(jal), .i_is_jalr(jalr), .i_is_branch(br), .i_is_compressed(comp),
    .o_valid(ov0), .o_branch_target(bt0), .o_jal_target(jt0), .o_link_addr(lk0),
    .o_ras_expected_rs1(ra0), .o_btb_expected_rs1(bb0),
    .o_btb_correct_non_jalr(cor0), .o_btb_false_hit(fh0)
  );

  branch_target_pipe #(.XLEN(32), .NUM_LANES(2), .SPLIT_COMPARE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_pc(pc), .i_imm_i(imm_i), .i_imm_b(imm_b), .i_imm_j(imm_j),
    .i_ras_target(ras), .i_btb_target(btb), .i_btb_hit(hit),
    .i_is_jal(jal), .i_is_jalr(jalr), .i_is_branch(br), .i_is_compressed(comp),
    .o_valid(ov1), .o_branch_target(bt1), .o_jal_target(jt1), .o_link_addr(lk1),
    .o_ras_expected_rs1(ra1), .o_btb_expected_rs1(bb1),
    .o_btb_correct_non_jalr(cor1), .o_btb_false_hit(fh1)
  );

  // Hand-computed lane vectors: inputs, then expected bt, jt, link, ras_rs1, btb_rs1, correct, false_hit.
  function automatic vec_t vec(input int i);
    vec_t v;
    case (i)
      0: v = '{32'h0000_1000, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0FF0,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               32'h0000_0FF0, 32'h0000_1010, 32'h0000_1004, 32'h0000_0000, 32'h0000_0FF0, 1'b1, 1'b0};
      1: v = '{32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0100, 32'h0000_0008, 32'h0000_0010, 32'h0000_0004,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
               32'h0000_00FC, 32'h0000_0004, 32'hFFFF_FFFE, 32'h0000_000C, 32'h0000_0000, 1'b1, 1'b0};
      2: v = '{32'h0000_3000, 32'hFFFF_FFFC, 32'h0000_0020, 32'h0000_0040, 32'h0000_2000, 32'h0000_5000,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0000_3020, 32'h0000_3040, 32'h0000_3004, 32'h0000_2004, 32'h0000_5004, 1'b0, 1'b1};
      3: v = '{32'h0000_0100, 32'h0000_0008, 32'hFFFF_FF00, 32'h0000_0004, 32'h0000_0008, 32'h0000_1234,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
               32'h0000_0000, 32'h0000_0104, 32'h0000_0102, 32'h0000_0000, 32'h0000_122C, 1'b0, 1'b0};
      4: v = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0004,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0004, 32'h8000_0001, 32'h8000_0005, 1'b0, 1'b0};
      5: v = '{32'h0000_0040, 32'h0000_0010, 32'h0000_0008, 32'hFFFF_FFC0, 32'h0000_0050, 32'h0000_0000,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               32'h0000_0048, 32'h0000_0000, 32'h0000_0044, 32'h0000_0040, 32'hFFFF_FFF0, 1'b0, 1'b0};
      6: v = '{32'h0000_0200, 32'h0000_0000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0300, 32'h0000_0210,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
               32'h0000_0210, 32'h0000_0220, 32'h0000_0202, 32'h0000_0300, 32'h0000_0210, 1'b0, 1'b0};
      7: v = '{32'h0000_7000, 32'h0000_0001, 32'hFFFF_F000, 32'h0000_0008, 32'h0000_0001, 32'h0000_6000,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               32'h0000_6000, 32'h0000_7008, 32'h0000_7004, 32'h0000_0000, 32'h0000_5FFF, 1'b1, 1'b0};
      default: v = '{default: '0};
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic cmp_lanes(input int d, input exp_t e,
                           input logic [1:0][31:0] bt, input logic [1:0][31:0] jt,
                           input logic [1:0][31:0] lk, input logic [1:0][31:0] ra,
                           input logic [1:0][31:0] bb, input logic [1:0] cor, input logic [1:0] fh);
    vec_t v;
    for (int l = 0; l < 2; l++) begin
      if (e.mask[l]) begin
        v = vec((l == 0) ? e.a : e.b);
        chk($sformatf("d%0d.l%0d.branch_target", d, l), bt[l], v.e_bt);
        chk($sformatf("d%0d.l%0d.jal_target", d, l), jt[l], v.e_jt);
        chk($sformatf("d%0d.l%0d.link_addr", d, l), lk[l], v.e_link);
        chk($sformatf("d%0d.l%0d.ras_rs1", d, l), ra[l], v.e_ras);
        chk($sformatf("d%0d.l%0d.btb_rs1", d, l), bb[l], v.e_btb);
        chk($sformatf("d%0d.l%0d.correct", d, l), {31'd0, cor[l]}, {31'd0, v.e_cor});
        chk($sformatf("d%0d.l%0d.false_hit", d, l), {31'd0, fh[l]}, {31'd0, v.e_fh});
      end
    end
  endtask

  // Monitor: samples both DUTs away from the active edge and pops the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [1:0] v_s, cor_s, fh_s;
      logic [1:0][31:0] bt_s, jt_s, lk_s, ra_s, bb_s;
      exp_t e;
      bit have;
      if (d == 0) begin
        v_s = ov0; cor_s = cor0; fh_s = fh0; bt_s = bt0; jt_s = jt0; lk_s = lk0; ra_s = ra0; bb_s = bb0;
      end else begin
        v_s = ov1; cor_s = cor1; fh_s = fh1; bt_s = bt1; jt_s = jt1; lk_s = lk1; ra_s = ra1; bb_s = bb1;
      end
      if (kind != K_NONE)
        chk($sformatf("d%0d.flag_gate", d), {30'd0, (cor_s | fh_s) & ~v_s}, 32'd0);
      case (kind)
        K_RESET: begin
          chk($sformatf("d%0d.reset_valid", d), {30'd0, v_s}, 32'd0);
          chk($sformatf("d%0d.reset_data", d),
              bt_s[0] | bt_s[1] | jt_s[0] | jt_s[1] | lk_s[0] | lk_s[1] | ra_s[0] | ra_s[1] |
              bb_s[0] | bb_s[1] | {30'd0, cor_s | fh_s}, 32'd0);
          last_exp[d].mask = 2'b00;
        end
        K_FLUSH: begin
          chk($sformatf("d%0d.flush_valid", d), {30'd0, v_s}, 32'd0);
          last_exp[d].mask = 2'b00;
        end
        K_STALL: begin
          chk($sformatf("d%0d.stall_valid", d), {30'd0, v_s}, {30'd0, last_exp[d].mask});
          cmp_lanes(d, last_exp[d], bt_s, jt_s, lk_s, ra_s, bb_s, cor_s, fh_s);
        end
        K_LOAD: begin
          have = 1'b0;
          if (d == 0) begin
            if (q0.size() > 0 && q0[0].due == adv_cnt) begin e = q0.pop_front(); have = 1'b1; end
          end else begin
            if (q1.size() > 0 && q1[0].due == adv_cnt) begin e = q1.pop_front(); have = 1'b1; end
          end
          if (have) begin
            chk($sformatf("d%0d.result_valid", d), {30'd0, v_s}, {30'd0, e.mask});
            cmp_lanes(d, e, bt_s, jt_s, lk_s, ra_s, bb_s, cor_s, fh_s);
            last_exp[d] = e;
          end else begin
            chk($sformatf("d%0d.bubble_valid", d), {30'd0, v_s}, 32'd0);
            last_exp[d].mask = 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // One clock of stimulus: lane0 gets vector a, lane1 vector b.
  task automatic step(input int a, input int b, input logic [1:0] vm,
                      input logic st, input logic fl, input logic rs);
    vec_t va, vb;
    exp_t e;
    va = vec(a);
    vb = vec(b);
    rst = rs; stall = st; flush = fl; valid = vm;
    pc[0] = va.pc;       pc[1] = vb.pc;
    imm_i[0] = va.imm_i; imm_i[1] = vb.imm_i;
    imm_b[0] = va.imm_b; imm_b[1] = vb.imm_b;
    imm_j[0] = va.imm_j; imm_j[1] = vb.imm_j;
    ras[0] = va.ras;     ras[1] = vb.ras;
    btb[0] = va.btb;     btb[1] = vb.btb;
    hit  = {vb.hit, va.hit};
    jal  = {vb.jal, va.jal};
    jalr = {vb.jalr, va.jalr};
    br   = {vb.br, va.br};
    comp = {vb.comp, va.comp};
    if (!rs && !fl && !st && vm != 2'b00) begin
      e.mask = vm; e.a = a; e.b = b;
      e.due = adv_cnt + 1; q0.push_back(e);
      e.due = adv_cnt + 2; q1.push_back(e);
    end
    @(posedge clk);
    if (rs) begin
      kind = K_RESET; q0.delete(); q1.delete();
    end else if (fl) begin
      kind = K_FLUSH; q0.delete(); q1.delete();
    end else if (st) begin
      kind = K_STALL;
    end else begin
      kind = K_LOAD; adv_cnt++;
    end
    #1;
  endtask

  initial begin
    last_exp[0] = '{mask: 2'b00, a: 0, b: 0, due: 0};
    last_exp[1] = '{mask: 2'b00, a: 0, b: 0, due: 0};
    // Reset wins over valid inputs
    step(0, 1, 2'b11, 1'b0, 1'b0, 1'b1);
    step(2, 3, 2'b11, 1'b1, 1'b1, 1'b1);
    // Back-to-back stream
    step(0, 1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(2, 3, 2'b11, 1'b0, 1'b0, 1'b0);
    step(4, 5, 2'b11, 1'b0, 1'b0, 1'b0);
    step(6, 7, 2'b11, 1'b0, 1'b0, 1'b0);
    // Three-cycle stall with changing (ignored) inputs
    step(1, 0, 2'b11, 1'b0, 1'b0, 1'b0);
    step(2, 3, 2'b11, 1'b1, 1'b0, 1'b0);
    step(4, 5, 2'b11, 1'b1, 1'b0, 1'b0);
    step(6, 7, 2'b11, 1'b1, 1'b0, 1'b0);
    step(5, 6, 2'b11, 1'b0, 1'b0, 1'b0);
    step(7, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    // Partial lane masks
    step(3, 4, 2'b01, 1'b0, 1'b0, 1'b0);
    step(0, 6, 2'b10, 1'b0, 1'b0, 1'b0);
    step(0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(7, 7, 2'b11, 1'b0, 1'b0, 1'b0);
    // Flush together with stall while outputs are valid
    step(1, 2, 2'b11, 1'b1, 1'b1, 1'b0);
    step(0, 1, 2'b11, 1'b0, 1'b0, 1'b0);
    // Plain flush discards the inputs of the same edge
    step(2, 3, 2'b11, 1'b0, 1'b1, 1'b0);
    step(4, 5, 2'b11, 1'b0, 1'b0, 1'b0);
    step(6, 7, 2'b11, 1'b0, 1'b0, 1'b0);
    // Reset mid-stream, with stall and flush also high
    step(1, 2, 2'b11, 1'b1, 1'b1, 1'b1);
    // Lane 1 invalid but carrying a BTB hit that would flag if ungated
    step(2, 0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(3, 1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("d0.drained", q0.size(), 32'd0);
    chk("d1.drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
